// File: rtl/eth_cmd_ctrl_pkg.sv
// Shared types and constants for the Ethernet command controller.
// Packet layout: MAGIC, N, then N records of {addr, data[31:0]}.
package eth_cmd_ctrl_pkg;

  localparam logic [7:0] DEF_MAGIC = 8'h47;
  localparam int DEF_MAX_REC = 12;
  localparam int REC_LEN = 5;
  localparam int HDR_LEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_WRITE,
    S_RELEASE,
    S_DRAIN
  } state_t;

  function automatic logic [5:0] rec_base(input logic [3:0] k);
    return 6'(HDR_LEN + REC_LEN * int'(k));
  endfunction

endpackage

// File: rtl/eth_cmd_ctrl_rec_fetch.sv
// Reads one 5-byte record from packet RAM (1-cycle read latency).
// Ports: start/base in, addr to RAM, done pulse with {addr,data} record.
module eth_cmd_ctrl_rec_fetch
  import eth_cmd_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  base,
  input  logic [7:0]  ram_rdata,
  output logic [5:0]  addr,
  output logic        done,
  output logic [39:0] rec
);

  logic        busy;
  logic [2:0]  cnt;
  logic [31:0] sh;

  // Last byte is taken straight from the RAM so the record
  // is complete in the same cycle done is raised.
  assign done = busy && (cnt == 3'd5);
  assign rec  = {sh, ram_rdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= 3'd0;
      addr <= 6'd0;
      sh   <= 32'd0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= 3'd0;
      addr <= base;
    end else if (busy) begin
      cnt <= cnt + 3'd1;
      if (cnt < 3'd4)
        addr <= addr + 6'd1;
      if (cnt != 3'd0 && cnt < 3'd5)
        sh <= {sh[23:0], ram_rdata};
      if (cnt == 3'd5)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/eth_cmd_ctrl.sv
// Executes command packets from the Ethernet receive RAM as cfg writes.
// Ports: rx ready/read handshake, RAM read port, cfg bus, good/bad counters.
module eth_cmd_ctrl
  import eth_cmd_ctrl_pkg::*;
#(
  parameter logic [7:0] MAGIC = DEF_MAGIC,
  parameter int MAX_REC = DEF_MAX_REC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eth_rx_ready,
  output logic        eth_rx_read,
  output logic [5:0]  ram_addr,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  cfg_addr,
  output logic [31:0] cfg_wdata,
  output logic        cfg_we,
  input  logic        cfg_ack,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  state_t      state, state_nx;
  logic [1:0]  hcnt, hcnt_nx;
  logic [5:0]  h_addr, h_addr_nx;
  logic [7:0]  byte0, byte0_nx;
  logic [3:0]  nrec, nrec_nx;
  logic [3:0]  k, k_nx;
  logic        good, good_nx;
  logic [7:0]  addr_nx;
  logic [31:0] wdata_nx;
  logic        we_nx;
  logic [15:0] good_cnt_nx, bad_cnt_nx;

  logic        f_start;
  logic [5:0]  f_base;
  logic [5:0]  f_addr;
  logic        f_done;
  logic [39:0] f_rec;
  logic        hdr_bad;

  eth_cmd_ctrl_rec_fetch u_fetch (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (f_start),
    .base      (f_base),
    .ram_rdata (ram_rdata),
    .addr      (f_addr),
    .done      (f_done),
    .rec       (f_rec)
  );

  // Evaluated in the last HDR cycle, when ram_rdata holds N.
  assign hdr_bad = (byte0 != MAGIC) ||
                   (ram_rdata == 8'd0) ||
                   (int'(ram_rdata) > MAX_REC);

  assign eth_rx_read = (state == S_RELEASE);
  assign ram_addr = (state == S_FETCH) ? f_addr : h_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hcnt      <= 2'd0;
      h_addr    <= 6'd0;
      byte0     <= 8'd0;
      nrec      <= 4'd0;
      k         <= 4'd0;
      good      <= 1'b0;
      cfg_addr  <= 8'd0;
      cfg_wdata <= 32'd0;
      cfg_we    <= 1'b0;
      good_cnt  <= 16'd0;
      bad_cnt   <= 16'd0;
    end else begin
      state     <= state_nx;
      hcnt      <= hcnt_nx;
      h_addr    <= h_addr_nx;
      byte0     <= byte0_nx;
      nrec      <= nrec_nx;
      k         <= k_nx;
      good      <= good_nx;
      cfg_addr  <= addr_nx;
      cfg_wdata <= wdata_nx;
      cfg_we    <= we_nx;
      good_cnt  <= good_cnt_nx;
      bad_cnt   <= bad_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    hcnt_nx     = hcnt;
    h_addr_nx   = h_addr;
    byte0_nx    = byte0;
    nrec_nx     = nrec;
    k_nx        = k;
    good_nx     = good;
    addr_nx     = cfg_addr;
    wdata_nx    = cfg_wdata;
    we_nx       = cfg_we;
    good_cnt_nx = good_cnt;
    bad_cnt_nx  = bad_cnt;
    f_start     = 1'b0;
    f_base      = rec_base(4'd0);
    unique case (state)
      S_IDLE: begin
        h_addr_nx = 6'd0;
        hcnt_nx   = 2'd0;
        if (eth_rx_ready)
          state_nx = S_HDR;
      end
      S_HDR: begin
        hcnt_nx = hcnt + 2'd1;
        case (hcnt)
          2'd0: h_addr_nx = 6'd1;
          2'd1: byte0_nx = ram_rdata;
          default: begin
            if (hdr_bad) begin
              good_nx  = 1'b0;
              state_nx = S_RELEASE;
            end else begin
              nrec_nx  = ram_rdata[3:0];
              k_nx     = 4'd0;
              f_start  = 1'b1;
              state_nx = S_FETCH;
            end
          end
        endcase
      end
      S_FETCH: begin
        if (f_done) begin
          addr_nx  = f_rec[39:32];
          wdata_nx = f_rec[31:0];
          we_nx    = 1'b1;
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cfg_ack) begin
          we_nx = 1'b0;
          if (k == nrec - 4'd1) begin
            good_nx  = 1'b1;
            state_nx = S_RELEASE;
          end else begin
            k_nx     = k + 4'd1;
            f_start  = 1'b1;
            f_base   = rec_base(k + 4'd1);
            state_nx = S_FETCH;
          end
        end
      end
      S_RELEASE: begin
        if (good)
          good_cnt_nx = good_cnt + 16'd1;
        else
          bad_cnt_nx = bad_cnt + 16'd1;
        state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        // Wait for the receiver to drop ready so a stale
        // payload is never executed twice.
        if (!eth_rx_ready)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_cmd_ctrl.sv
// Directed bench for eth_cmd_ctrl with RAM and receiver models.
// Records cfg writes and release pulses per packet and checks them.
module tb_eth_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        eth_rx_ready;
  logic        eth_rx_read;
  logic [5:0]  ram_addr;
  logic [7:0]  ram_rdata;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_we;
  logic        cfg_ack;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  logic [7:0]  mem [64];
  logic [7:0]  wa [16];
  logic [31:0] wd [16];
  int          whold [16];
  int          nw, rds, maxa, unstable;
  int          checks = 0;
  int          errors = 0;

  eth_cmd_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .eth_rx_ready (eth_rx_ready),
    .eth_rx_read  (eth_rx_read),
    .ram_addr     (ram_addr),
    .ram_rdata    (ram_rdata),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_we       (cfg_we),
    .cfg_ack      (cfg_ack),
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ra(input int k);
    return 8'(16 + 3 * k);
  endfunction

  function automatic logic [31:0] rd(input int k);
    return 32'h11223344 + 32'(k) * 32'h01010101;
  endfunction

  task automatic load(input logic [7:0] b0, input logic [7:0] nf);
    logic [31:0] d;
    mem[0] = b0;
    mem[1] = nf;
    for (int k = 0; k < 12; k++) begin
      d = rd(k);
      mem[2 + 5 * k] = ra(k);
      mem[3 + 5 * k] = d[31:24];
      mem[4 + 5 * k] = d[23:16];
      mem[5 + 5 * k] = d[15:8];
      mem[6 + 5 * k] = d[7:0];
    end
    mem[62] = 8'hFF;
    mem[63] = 8'hFF;
  endtask

  task automatic rst_outs(input string p);
    chk({p, "_we"}, 32'(cfg_we), 0);
    chk({p, "_read"}, 32'(eth_rx_read), 0);
    chk({p, "_raddr"}, 32'(ram_addr), 0);
    chk({p, "_caddr"}, 32'(cfg_addr), 0);
    chk({p, "_wdata"}, cfg_wdata, 0);
    chk({p, "_good"}, 32'(good_cnt), 0);
    chk({p, "_bad"}, 32'(bad_cnt), 0);
  endtask

  // One packet: raise ready, serve acks after `delay` extra cycles
  // (0 = ack tied high), hold ready `hold_x` cycles past the release
  // pulse, optionally reset at the first cycle of write `rst_at`.
  task automatic run_packet(input int delay, input int hold_x,
                            input int rst_at, input int settle);
    int cyc, wecnt, idle, hx;
    bit seen, fin;
    nw = 0; rds = 0; maxa = 0; unstable = 0;
    cyc = 0; wecnt = 0; idle = 0; hx = hold_x;
    seen = 0; fin = 0;
    eth_rx_ready = 1'b1;
    cfg_ack = (delay == 0);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        chk("timeout", 32'(cyc), 0);
        fin = 1;
      end else begin
        if (int'(ram_addr) > maxa) maxa = int'(ram_addr);
        if (cfg_we) begin
          if (wecnt == 0) begin
            wa[nw] = cfg_addr;
            wd[nw] = cfg_wdata;
          end else if (cfg_addr != wa[nw] || cfg_wdata != wd[nw]) begin
            unstable++;
          end
          wecnt++;
        end else if (wecnt != 0) begin
          whold[nw] = wecnt;
          if (nw < 15) nw++;
          wecnt = 0;
        end
        if (rst_at != 0 && cfg_we && wecnt == 1 && nw == rst_at - 1) begin
          chk("pre_rst_read", 32'(rds), 0);
          cfg_ack = 1'b0;
          rst_n = 1'b0;
          @(negedge clk);
          cyc++;
          rst_outs("midrst");
          rst_n = 1'b1;
          nw = 0; wecnt = 0; rst_at = 0; maxa = 0; unstable = 0;
        end else begin
          if (delay != 0)
            cfg_ack = cfg_we && (wecnt == delay + 1);
          if (eth_rx_read) begin
            rds++;
            seen = 1;
          end
          if (seen) begin
            if (hx > 0) hx--;
            else eth_rx_ready = 1'b0;
          end
          if (seen && !eth_rx_ready) begin
            idle++;
            if (idle > settle) fin = 1;
          end
        end
      end
    end
    cfg_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    eth_rx_ready = 1'b0;
    cfg_ack = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    load(8'h47, 8'h01);
    mem[2] = 8'h10;
    mem[3] = 8'hDE;
    mem[4] = 8'hAD;
    mem[5] = 8'hBE;
    mem[6] = 8'hEF;
    run_packet(0, 0, 0, 3);
    chk("p1_nw", 32'(nw), 1);
    chk("p1_addr", 32'(wa[0]), 32'h10);
    chk("p1_data", wd[0], 32'hDEADBEEF);
    chk("p1_hold", 32'(whold[0]), 1);
    chk("p1_reads", 32'(rds), 1);
    chk("p1_good", 32'(good_cnt), 1);
    chk("p1_bad", 32'(bad_cnt), 0);

    load(8'h48, 8'h01);
    run_packet(1, 0, 0, 3);
    chk("magic_nw", 32'(nw), 0);
    chk("magic_reads", 32'(rds), 1);
    chk("magic_bad", 32'(bad_cnt), 1);

    load(8'h47, 8'h00);
    run_packet(1, 0, 0, 3);
    chk("n0_nw", 32'(nw), 0);
    chk("n0_reads", 32'(rds), 1);
    chk("n0_bad", 32'(bad_cnt), 2);

    load(8'h47, 8'd13);
    run_packet(1, 0, 0, 3);
    chk("n13_nw", 32'(nw), 0);
    chk("n13_reads", 32'(rds), 1);
    chk("n13_bad", 32'(bad_cnt), 3);
    chk("n13_good", 32'(good_cnt), 1);

    load(8'h47, 8'd12);
    run_packet(3, 0, 0, 3);
    chk("n12_nw", 32'(nw), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("n12_addr%0d", i), 32'(wa[i]), 32'(ra(i)));
      chk($sformatf("n12_data%0d", i), wd[i], rd(i));
      chk($sformatf("n12_hold%0d", i), 32'(whold[i]), 4);
    end
    chk("n12_stable", 32'(unstable), 0);
    chk("n12_maxaddr", 32'(maxa), 61);
    chk("n12_reads", 32'(rds), 1);
    chk("n12_good", 32'(good_cnt), 2);

    load(8'h47, 8'h01);
    run_packet(1, 2, 0, 20);
    chk("slow_nw", 32'(nw), 1);
    chk("slow_reads", 32'(rds), 1);
    chk("slow_good", 32'(good_cnt), 3);

    load(8'h47, 8'h02);
    run_packet(1, 0, 0, 2);
    chk("b2b1_nw", 32'(nw), 2);
    chk("b2b1_reads", 32'(rds), 1);
    run_packet(1, 0, 0, 4);
    chk("b2b2_nw", 32'(nw), 2);
    chk("b2b2_addr1", 32'(wa[1]), 32'(ra(1)));
    chk("b2b2_reads", 32'(rds), 1);
    chk("b2b_good", 32'(good_cnt), 5);

    load(8'h47, 8'h05);
    run_packet(1, 0, 3, 3);
    chk("rst_nw", 32'(nw), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rst_addr%0d", i), 32'(wa[i]), 32'(ra(i)));
    chk("rst_data4", wd[4], rd(4));
    chk("rst_reads", 32'(rds), 1);
    chk("rst_good", 32'(good_cnt), 1);
    chk("rst_bad", 32'(bad_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_cmd_ctrl.md
Name: eth_cmd_ctrl

Overview:
Consumes command packets that the Ethernet receiver leaves in its 64-byte packet RAM, then releases the RAM back to the receiver.
Walks the payload and validates the header. Issues a sequence of 32-bit register writes on the front-end configuration bus, then pulses the receiver's read/release strobe.
Sits between the Ethernet receiver (packet RAM read port plus ready/read handshake) and the configuration register file.

Parameters:
MAGIC, 8'h47, required value of payload byte 0.
MAX_REC, 12, maximum number of records per packet; 2+5*12=62 bytes fits the 64-byte RAM.

Ports:
clk  in  1  system clock, the Ethernet receive clock domain.
rst_n  in  1  synchronous, active-low reset.
eth_rx_ready  in  1  receiver has a complete 64-byte payload in RAM.
eth_rx_read  out  1  one-cycle release pulse to the receiver.
ram_addr  out  6  packet RAM read address.
ram_rdata  in  8  packet RAM read data, valid exactly 1 cycle after ram_addr.
cfg_addr  out  8  register address.
cfg_wdata  out  32  register write data.
cfg_we  out  1  write request; held until cfg_ack.
cfg_ack  in  1  register file accepted the write.
good_cnt  out  16  packets fully executed, wraps at 16'hFFFF.
bad_cnt  out  16  packets rejected, wraps at 16'hFFFF.

Behaviour:
- Reset values (rst_n=0 at a clk edge): state IDLE; eth_rx_read=0; cfg_we=0; ram_addr=0; cfg_addr=0; cfg_wdata=0; good_cnt=0; bad_cnt=0. Reset mid-packet abandons the packet with no release pulse; the receiver stays in WAIT and is re-serviced after reset.
- Packet layout:
  - byte0 = MAGIC.
  - byte1 = N.
  - Each record occupies 5 bytes: addr, then data[31:24], data[23:16], data[15:8], data[7:0] (big-endian).
  - Record k starts at byte 2+5k.
- States:
  - IDLE: ram_addr<=0. If eth_rx_ready, go to HDR.
  - HDR: 3 cycles. Issue addr 0, then addr 1; capture byte0 at cycle 2 and byte1 at cycle 3. Reject if byte0!=MAGIC, N==0 or N>MAX_REC. On reject go to RELEASE with bad flag set; otherwise k<=0 and go to FETCH.
  - FETCH: issue 5 consecutive addresses starting at 2+5k, one per cycle. Assemble cfg_addr and cfg_wdata from the 1-cycle-delayed ram_rdata; total 6 cycles. Then assert cfg_we and go to WRITE.
  - WRITE: hold cfg_we, cfg_addr and cfg_wdata stable until cfg_ack=1. In the cycle after ack, cfg_we=0. If k==N-1, go to RELEASE with good flag set; else k<=k+1 and go to FETCH. cfg_ack is ignored outside WRITE.
  - RELEASE: eth_rx_read=1 for exactly one cycle. Increment good_cnt or bad_cnt in the same cycle. Go to DRAIN.
  - DRAIN: wait until eth_rx_ready==0 (the receiver clears ready one cycle after the read pulse), then go to IDLE. This prevents re-processing a stale payload.
- Boundary conditions:
  - Records are executed strictly in order, with no overlap between fetch and write.
  - A zero-wait-state cfg_ack (ack in the first WRITE cycle) gives exactly one cycle of cfg_we per record.
  - eth_rx_ready dropping before RELEASE is illegal stimulus; the block ignores it and completes the sequence.
  - ram_addr never exceeds 61.

Decomposition:
- Shared package: MAGIC default, MAX_REC, record length 5, header length 2, state encoding constants.
- One natural sub-module, eth_cmd_rec_fetch: 6-bit base address in, start/done handshake, 40-bit {addr,data} record out. It owns the read-latency pipeline.

Test Plan:
- Valid packet 47 01 10 DE AD BE EF, cfg_ack tied 1 -> one cfg_we pulse with cfg_addr=8'h10, cfg_wdata=32'hDEADBEEF; one eth_rx_read pulse; good_cnt=1, bad_cnt=0.
- Bad magic 48 01 ... -> no cfg_we, one eth_rx_read pulse, bad_cnt=1. N=0 and N=13 -> same result.
- N=12 with cfg_ack delayed 3 cycles per write -> 12 writes in address order, each with cfg_we held 4 cycles and data stable; last RAM address read is 61; one release.
- eth_rx_ready held high 2 cycles after release (slow receiver) -> block stays in DRAIN; no second processing or extra pulse.
- rst_n low during the third WRITE of N=5 -> all outputs return to reset values next edge, no eth_rx_read. After release of reset with eth_rx_ready still high, the packet is re-executed from record 0 and good_cnt=1.
- Back-to-back packets (ready re-asserted 1 cycle after DRAIN exit) -> both processed; good_cnt=2.
